// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: request/result bundle between the EX stage and the
// multi-cycle multiply sequencer.
//   start_i, ALUCtrl_i  request strobe and ALU control code (3'b111 = mul)
//   data1_i, data2_i    multiplicand / multiplier
//   flush_i             abort an operation in progress
//   stall_o             pipeline stall request
//   busy_o, done_o      RUN indicator, one-cycle completion pulse
//   result_o            low WIDTH bits of the product
// master: pipeline side; slave: sequencer side.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-add multiplier for the EX stage. Accepts a
// mul request (ALUCtrl_i = 3'b111), runs one shift-add step per cycle and
// returns the low WIDTH bits of the product, stalling the pipeline meanwhile.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-low reset
//   bus    mul_seq_ctrl_if slave modport (request, flush, stall, result)
// Build option: define MUL_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero (variable latency, same result).
//
// state   | meaning
// IDLE    | waiting for a mul request
// RUN     | one shift-add step per cycle
// DONE    | result_o valid, done_o pulsed for one cycle
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mul_seq_ctrl_if.slave  bus
);
  localparam int             CW      = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic [2:0]     ALU_MUL = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;
  logic             accept;
  logic             zero_exit;

  assign accept   = (state == ST_IDLE) && bus.start_i && (bus.ALUCtrl_i == ALU_MUL);
  assign acc_next = mplier[0] ? acc + mcand : acc;

`ifdef MUL_EARLY_TERM_EN
  assign zero_exit = (mplier == '0);
`else
  assign zero_exit = 1'b0;
`endif

  // Stall starts combinationally in the accept cycle and drops in DONE so
  // the pipeline advances while result_o is valid.
  assign bus.stall_o  = accept || (state == ST_RUN);
  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.result_o = result;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            mcand  <= bus.data1_i;
            mplier <= bus.data2_i;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.flush_i) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (zero_exit) begin
            result <= acc;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (count == LAST) begin
              // final step's accumulate goes straight into the result
              result <= acc_next;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;
  localparam int WIDTH = 32;

  logic clk_i = 1'b0;
  logic rst_i;

  mul_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b);
    int h;
    h = 0;
`ifdef MUL_EARLY_TERM_EN
    if (b == 32'd0) return 2;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return (h + 3 < WIDTH + 1) ? h + 3 : WIDTH + 1;
`else
    if (b[0] === 1'bx) h = 1;
    return WIDTH + 1 + h * 0;
`endif
  endfunction

  // Accept in cycle 0, then watch every cycle until done_o or a bounded timeout.
  // inj_at > 0 presents another mul request (3x3) during RUN at that cycle.
  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input int inj_at);
    int  cyc;
    int  bad_stall;
    bit  seen;
    cyc = -1;
    bad_stall = 0;
    seen = 0;
    @(posedge clk_i); #1;
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = 3'b111;
    bus.data1_i   = a;
    bus.data2_i   = b;
    @(negedge clk_i);
    chk({nm, "_stall_c0"}, 32'(bus.stall_o), 32'd1);
    for (int c = 1; c <= WIDTH + 8 && !seen; c++) begin
      @(posedge clk_i); #1;
      bus.start_i = (c == inj_at);
      bus.data1_i = 32'd3;
      bus.data2_i = 32'd3;
      @(negedge clk_i);
      if (bus.done_o) begin
        seen = 1;
        cyc  = c;
        chk({nm, "_stall_done"}, 32'(bus.stall_o), 32'd0);
        chk({nm, "_busy_done"}, 32'(bus.busy_o), 32'd0);
      end else if (!bus.stall_o || !bus.busy_o) begin
        bad_stall++;
      end
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat(b)));
    chk({nm, "_stall_run"}, 32'(bad_stall), 32'd0);
    chk({nm, "_result"}, bus.result_o, p);
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    @(negedge clk_i);
    chk({nm, "_done_drop"}, 32'(bus.done_o), 32'd0);
    chk({nm, "_result_hold"}, bus.result_o, p);
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (bus.done_o) pulses++;
    end
  endtask

  initial begin
    int pulses;

    vecs[0] = '{"v_7x6",      32'd7,          32'd6,          32'd42};
    vecs[1] = '{"v_ffxff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[2] = '{"v_msbx2",    32'h8000_0000,  32'd2,          32'h0000_0000};
    vecs[3] = '{"v_9x0",      32'd9,          32'd0,          32'd0};
    vecs[4] = '{"v_9x1",      32'd9,          32'd1,          32'd9};
    vecs[5] = '{"v_shift16",  32'h1234_5678,  32'h0000_0010,  32'h2345_6780};
    vecs[6] = '{"v_neg1xmsb", 32'hFFFF_FFFF,  32'h8000_0000,  32'h8000_0000};
    vecs[7] = '{"v_deadx3",   32'hDEAD_BEEF,  32'd3,          32'h9C09_3CCD};
    vecs[8] = '{"v_5x5",      32'd5,          32'd5,          32'd25};
    vecs[9] = '{"v_3x4",      32'd3,          32'd4,          32'd12};

    rst_i         = 1'b0;
    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    bus.flush_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_stall",  32'(bus.stall_o), 32'd0);
    chk("rst_busy",   32'(bus.busy_o),  32'd0);
    chk("rst_done",   32'(bus.done_o),  32'd0);
    chk("rst_result", bus.result_o,     32'd0);

    // Basic multiply with a second mul request arriving mid-RUN.
    run_mul("basic", 32'd7, 32'd6, 32'd42, 5);

    // Non-mul request is ignored.
    @(posedge clk_i); #1;
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = 3'b010;
    bus.data1_i   = 32'd11;
    bus.data2_i   = 32'd11;
    @(negedge clk_i);
    chk("nonmul_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk_i); #1;
    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = 3'b111;
    @(negedge clk_i);
    chk("nonmul_busy", 32'(bus.busy_o), 32'd0);
    count_done(WIDTH + 4, pulses);
    chk("nonmul_no_done", 32'(pulses), 32'd0);
    chk("nonmul_result", bus.result_o, 32'd42);

    for (int i = 0; i < 10; i++)
      run_mul(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].p, 0);

    // Flush at cycle 10 of a 5x5; previous result is 12.
    @(posedge clk_i); #1;
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = 3'b111;
    bus.data1_i   = 32'd5;
    bus.data2_i   = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      bus.flush_i = (c == 10);
    end
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy",  32'(bus.busy_o),  32'd0);
    chk("flush_stall", 32'(bus.stall_o), 32'd0);
    count_done(WIDTH + 4, pulses);
    chk("flush_no_done", 32'(pulses), 32'd0);
    chk("flush_result", bus.result_o, 32'd12);
    run_mul("after_flush", 32'd3, 32'd4, 32'd12, 0);

    // Flush in IDLE has no effect on the next operation.
    @(posedge clk_i); #1;
    bus.flush_i = 1'b1;
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0;
    run_mul("idle_flush", 32'd7, 32'd6, 32'd42, 0);

    // Reset mid-RUN discards the operation and clears the result.
    @(posedge clk_i); #1;
    bus.start_i = 1'b1;
    bus.data1_i = 32'd100;
    bus.data2_i = 32'd100;
    repeat (5) begin
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
    end
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_stall",  32'(bus.stall_o), 32'd0);
    chk("midrst_busy",   32'(bus.busy_o),  32'd0);
    chk("midrst_result", bus.result_o,     32'd0);
    count_done(WIDTH + 4, pulses);
    chk("midrst_no_done", 32'(pulses), 32'd0);
    chk("midrst_result_hold", bus.result_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
